ps2_rx_decoder: RTL and testbench

Parametrised PS/2 keyboard receiver: synchronises and glitch-filters the PS/2 clock and data lines, deframes 11-bit frames with start/parity/stop checking and inter-bit timeout, folds E0/F0 prefix bytes into make/break/extended key events, and buffers events in a FIFO with a valid/ready interface. It sits between the PS/2 pins and the key-to-note logic of the piano, replacing the bare bit-counter scanner.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_frame_rx.sv | 141 ++++++++++++++
 rtl/ps2_rx_decoder.sv | 131 +++++++++++++
 tb/tb_ps2_rx_decoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_STOP    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // PS/2 frames carry odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 pin conditioning and 11-bit frame deframer with parity, stop and timeout checks.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2k_clk,
  input  logic       ps2k_data,
  output logic       byte_stb,
  output logic [7:0] byte_data,
  output logic       err_stb,
  output logic [1:0] err_code
);

  localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]      FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [TW-1:0]   TMO_LIM   = TW'(TIMEOUT_CYCLES);

  logic          clk_meta_r;
  logic          clk_sync_r;
  logic          data_meta_r;
  logic          data_sync_r;
  logic          filt_clk_r;
  logic [3:0]    filt_cnt_r;
  logic          fall_r;
  ps2_state_t    state_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          par_r;
  logic [TW-1:0] tmo_cnt_r;

  // Two-flop synchronisers for both pins; idle-high reset level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2k_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2k_data;
      data_sync_r <= data_meta_r;
    end
  end

  // Glitch filter: the filtered clock follows only after FILTER_LEN agreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_clk_r <= 1'b1;
      filt_cnt_r <= 4'd0;
      fall_r     <= 1'b0;
    end else if (clk_sync_r != filt_clk_r) begin
      if (filt_cnt_r == FILT_LAST) begin
        filt_clk_r <= clk_sync_r;
        filt_cnt_r <= 4'd0;
        fall_r     <= ~clk_sync_r;
      end else begin
        filt_cnt_r <= filt_cnt_r + 4'd1;
        fall_r     <= 1'b0;
      end
    end else begin
      filt_cnt_r <= 4'd0;
      fall_r     <= 1'b0;
    end
  end

  // Frame FSM with inter-bit timeout; a falling edge wins over an expiring counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      par_r     <= 1'b0;
      tmo_cnt_r <= '0;
      byte_stb  <= 1'b0;
      byte_data <= 8'h00;
      err_stb   <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      byte_stb <= 1'b0;
      err_stb  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tmo_cnt_r <= '0;
          if (fall_r && !data_sync_r) begin
            state_r   <= ST_DATA;
            bit_idx_r <= 3'd0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          if (fall_r) begin
            tmo_cnt_r <= '0;
            case (state_r)
              ST_DATA: begin
                shift_r   <= {data_sync_r, shift_r[7:1]};
                bit_idx_r <= bit_idx_r + 3'd1;
                if (bit_idx_r == 3'd7) begin
                  state_r <= ST_PARITY;
                end else begin
                  state_r <= ST_DATA;
                end
              end
              ST_PARITY: begin
                par_r   <= data_sync_r;
                state_r <= ST_STOP;
              end
              ST_STOP: begin
                state_r <= ST_IDLE;
                if (!data_sync_r) begin
                  err_stb  <= 1'b1;
                  err_code <= ERR_STOP;
                end else if (!odd_parity_ok(shift_r, par_r)) begin
                  err_stb  <= 1'b1;
                  err_code <= ERR_PARITY;
                end else begin
                  byte_stb  <= 1'b1;
                  byte_data <= shift_r;
                end
              end
              default: state_r <= ST_IDLE;
            endcase
          end else if (tmo_cnt_r == TMO_LIM) begin
            state_r   <= ST_IDLE;
            tmo_cnt_r <= '0;
            err_stb   <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: frame deframer, E0/F0 prefix folding and event FIFO.
module ps2_rx_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2k_clk,
  input  logic       ps2k_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic       byte_stb,
  output logic [7:0] byte_data,
  output logic       err_stb,
  output logic [1:0] err_code,
  output logic       ovf_stb
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  logic          ext_r;
  logic          brk_r;
  ps2_evt_t      mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          push_ok_s;
  logic [AW:0]   count_nxt_s;
  ps2_evt_t      new_evt_s;
  ps2_evt_t      head_s;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .clk      (clk),
    .rst      (rst),
    .ps2k_clk (ps2k_clk),
    .ps2k_data(ps2k_data),
    .byte_stb (byte_stb),
    .byte_data(byte_data),
    .err_stb  (err_stb),
    .err_code (err_code)
  );

  // Push/pop qualification; a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    push_s      = byte_stb && (byte_data != PS2_EXT) && (byte_data != PS2_BRK);
    pop_s       = evt_valid && evt_ready;
    full_s      = (count_r == FULL_LVL);
    push_ok_s   = push_s && (!full_s || pop_s);
    count_nxt_s = count_r + (AW + 1)'(push_ok_s) - (AW + 1)'(pop_s);
    new_evt_s   = '{ext: ext_r, brk: brk_r, code: byte_data};
    head_s      = mem_r[rd_ptr_r];
  end

  // Prefix flags live until the next real key byte or any rejected frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_r <= 1'b0;
      brk_r <= 1'b0;
    end else if (err_stb) begin
      ext_r <= 1'b0;
      brk_r <= 1'b0;
    end else if (byte_stb) begin
      if (byte_data == PS2_EXT) begin
        ext_r <= 1'b1;
      end else if (byte_data == PS2_BRK) begin
        brk_r <= 1'b1;
      end else begin
        ext_r <= 1'b0;
        brk_r <= 1'b0;
      end
    end else begin
      ext_r <= ext_r;
      brk_r <= brk_r;
    end
  end

  // FIFO storage; contents are only observable through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= new_evt_s;
    end
  end

  // FIFO pointers, occupancy, valid flag and overflow strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      evt_valid <= 1'b0;
      ovf_stb   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r   <= count_nxt_s;
      evt_valid <= (count_nxt_s != '0);
      ovf_stb   <= push_s && full_s && !pop_s;
    end
  end

  // Head event is forced to zero while the FIFO is empty.
  always_comb begin
    if (evt_valid) begin
      evt_code = head_s.code;
      evt_ext  = head_s.ext;
      evt_brk  = head_s.brk;
    end else begin
      evt_code = 8'h00;
      evt_ext  = 1'b0;
      evt_brk  = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed bench for ps2_rx_decoder: drives PS/2 frames on the pins and checks bytes, errors and events.
module tb_ps2_rx_decoder;

  localparam int FL    = 4;
  localparam int TMO   = 300;
  localparam int DEPTH = 4;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2k_clk;
  logic       ps2k_data;
  logic       evt_ready;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic       byte_stb;
  logic [7:0] byte_data;
  logic       err_stb;
  logic [1:0] err_code;
  logic       ovf_stb;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         byte_cnt = 0;
  int         err_cnt  = 0;
  int         ovf_cnt  = 0;
  int         vld_cycles = 0;
  int         cyc = 0;
  int         byte_cyc = 0;
  int         vld_rise_cyc = 0;
  logic       vld_prev = 1'b0;
  logic [7:0] last_byte = 8'h00;
  logic [1:0] last_err = 2'b00;
  logic [9:0] evq[$];

  always #5 clk = ~clk;

  ps2_rx_decoder #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TMO),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2k_clk (ps2k_clk),
    .ps2k_data(ps2k_data),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code (evt_code),
    .evt_ext  (evt_ext),
    .evt_brk  (evt_brk),
    .byte_stb (byte_stb),
    .byte_data(byte_data),
    .err_stb  (err_stb),
    .err_code (err_code),
    .ovf_stb  (ovf_stb)
  );

  // Monitor samples late in the low phase, after every input change of the cycle.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (byte_stb) begin
      byte_cnt++;
      last_byte = byte_data;
      byte_cyc  = cyc;
    end
    if (err_stb) begin
      err_cnt++;
      last_err = err_code;
    end
    if (ovf_stb) ovf_cnt++;
    if (evt_valid && !vld_prev) vld_rise_cyc = cyc;
    vld_prev = evt_valid;
    if (evt_valid) vld_cycles++;
    if (evt_valid && evt_ready) evq.push_back({evt_ext, evt_brk, evt_code});
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_evt(input string tag, input logic [9:0] exp);
    if (evq.size() == 0) begin
      check_val(tag, 32'hFFFF_FFFF, 32'(exp));
    end else begin
      check_val(tag, 32'(evq.pop_front()), 32'(exp));
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    byte_cnt   = 0;
    err_cnt    = 0;
    ovf_cnt    = 0;
    vld_cycles = 0;
    evq.delete();
  endtask

  // Sends the first nbits of an 11-bit frame: start, 8 data LSB first, odd parity, stop.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] frm;
    frm = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2k_data = frm[i];
      wait_cyc(HALF);
      ps2k_clk = 1'b0;
      wait_cyc(HALF);
      ps2k_clk = 1'b1;
    end
    ps2k_data = 1'b1;
    wait_cyc(HALF);
  endtask

  initial begin
    rst       = 1'b1;
    ps2k_clk  = 1'b1;
    ps2k_data = 1'b1;
    evt_ready = 1'b1;
    wait_cyc(5);
    check_val("rst_valid", 32'(evt_valid), 32'd0);
    check_val("rst_strobes", 32'({byte_stb, err_stb, ovf_stb}), 32'd0);
    check_val("rst_byte", 32'(byte_data), 32'h00);
    check_val("rst_err", 32'(err_code), 32'd0);
    check_val("rst_evt", 32'({evt_ext, evt_brk, evt_code}), 32'd0);
    rst = 1'b0;
    wait_cyc(10);

    // Make code 1C
    clr();
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    check_val("make_bytes", 32'(byte_cnt), 32'd1);
    check_val("make_byte", 32'(last_byte), 32'h1C);
    check_val("make_noerr", 32'(err_cnt), 32'd0);
    check_val("make_vld_cycles", 32'(vld_cycles), 32'd1);
    check_val("make_latency", 32'(vld_rise_cyc - byte_cyc), 32'd1);
    expect_evt("make_evt", {1'b0, 1'b0, 8'h1C});

    // Extended release E0 F0 75
    clr();
    send_frame(8'hE0, 1'b0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 1'b0, 11);
    check_val("ext_bytes", 32'(byte_cnt), 32'd3);
    check_val("ext_nevt", 32'(evq.size()), 32'd1);
    expect_evt("ext_evt", {1'b1, 1'b1, 8'h75});

    // Parity and stop errors
    clr();
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    check_val("par_errs", 32'(err_cnt), 32'd1);
    check_val("par_code", 32'(last_err), 32'd1);
    check_val("par_noevt", 32'(evq.size() + byte_cnt), 32'd0);
    clr();
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check_val("stop_errs", 32'(err_cnt), 32'd1);
    check_val("stop_code", 32'(last_err), 32'd2);

    // Error clears a pending break prefix
    clr();
    send_frame(8'hF0, 1'b0, 1'b0, 11);
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    check_val("flush_bytes", 32'(byte_cnt), 32'd2);
    check_val("flush_nevt", 32'(evq.size()), 32'd1);
    expect_evt("flush_evt", {1'b0, 1'b0, 8'h1C});

    // Timeout after 4 data bits, then recovery
    clr();
    send_frame(8'h1C, 1'b0, 1'b0, 5);
    wait_cyc(TMO + 50);
    check_val("tmo_errs", 32'(err_cnt), 32'd1);
    check_val("tmo_code", 32'(last_err), 32'd3);
    clr();
    send_frame(8'h2B, 1'b0, 1'b0, 11);
    check_val("tmo_recover_err", 32'(err_cnt), 32'd0);
    expect_evt("tmo_recover_evt", {1'b0, 1'b0, 8'h2B});

    // Overflow: DEPTH+1 codes with consumer stalled
    clr();
    evt_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) send_frame(8'h15 + 8'(i), 1'b0, 1'b0, 11);
    check_val("ovf_count", 32'(ovf_cnt), 32'd1);
    check_val("ovf_head", 32'({evt_valid, evt_code}), 32'h115);
    evt_ready = 1'b1;
    wait_cyc(20);
    check_val("ovf_drained", 32'(evq.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) expect_evt("ovf_order", {2'b00, 8'h15 + 8'(i)});

    // Push while full with a simultaneous pop
    clr();
    evt_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_frame(8'h15 + 8'(i), 1'b0, 1'b0, 11);
    fork
      send_frame(8'h24, 1'b0, 1'b0, 11);
      begin
        int k;
        k = 0;
        @(negedge clk);
        while (!byte_stb && k < 2000) begin
          @(negedge clk);
          k++;
        end
        check_val("simul_stb_seen", 32'(byte_stb), 32'd1);
        #1 evt_ready = 1'b1;
        @(posedge clk);
        #1 evt_ready = 1'b0;
      end
    join
    check_val("simul_no_ovf", 32'(ovf_cnt), 32'd0);
    evt_ready = 1'b1;
    wait_cyc(20);
    for (int i = 0; i < DEPTH; i++) expect_evt("simul_order", {2'b00, 8'h15 + 8'(i)});
    expect_evt("simul_last", {2'b00, 8'h24});

    // Short clock glitch with data low must not start a frame
    clr();
    ps2k_data = 1'b0;
    wait_cyc(5);
    ps2k_clk = 1'b0;
    wait_cyc(FL - 2);
    ps2k_clk = 1'b1;
    wait_cyc(40);
    ps2k_data = 1'b1;
    wait_cyc(10);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    check_val("glitch_err", 32'(err_cnt), 32'd0);
    check_val("glitch_byte", 32'({byte_cnt[7:0], last_byte}), 32'h011C);
    expect_evt("glitch_evt", {1'b0, 1'b0, 8'h1C});

    // Reset mid-frame with an E0 prefix pending
    clr();
    send_frame(8'hE0, 1'b0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 1'b0, 5);
    rst = 1'b1;
    wait_cyc(3);
    check_val("mrst_outs", 32'({evt_valid, byte_stb, err_stb, ovf_stb, err_code}), 32'd0);
    check_val("mrst_data", 32'({byte_data, evt_ext, evt_brk, evt_code}), 32'd0);
    rst = 1'b0;
    wait_cyc(20);
    clr();
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    check_val("mrst_err", 32'(err_cnt), 32'd0);
    expect_evt("mrst_evt", {1'b0, 1'b0, 8'h1C});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
